matrix_mult_pipe: RTL and testbench
===================================

MATRIX_MULT_PIPE -- requirements
Module: matrix_mult_pipe

Interface
REQ-001 SHALL have parameter BATCH_SIZE, default 8: rows of A and C (M).
REQ-002 SHALL have parameter LOG_BATCH_SIZE, default 3: width of row addresses.
REQ-003 SHALL have parameter INPUT_FEATURES, default 4: inner dimension (N).
REQ-004 SHALL have parameter OUTPUT_FEATURES, default 8: rows of B-transpose and columns of C (O).
REQ-005 SHALL have parameter LOG_OUTPUT_FEATURES, default 3: width of the weight address.
REQ-006 SHALL have parameters INPUT_WIDTH / WEIGHT_WIDTH / OUTPUT_WIDTH, defaults 4 / 8 / 16: element widths.
REQ-007 SHALL have parameter SIGNED, default 0: 1 = two's-complement operands, 0 = unsigned.
REQ-008 SHALL have parameter SATURATE, default 1: 1 = clamp results to OUTPUT_WIDTH, 0 = keep the low OUTPUT_WIDTH bits.
REQ-009 clk  in  1  sole clock; all state changes on its rising edge.
REQ-010 rst  in  1  asynchronous, active-low reset.
REQ-011 start  in  1  begin a full M x O multiply; honoured only in IDLE.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  single-cycle pulse when the last row of C has been accepted.
REQ-014 inputData  in  INPUT_FEATURES*INPUT_WIDTH  row of A; element k at bits [k*INPUT_WIDTH +: INPUT_WIDTH].
REQ-015 weightData  in  INPUT_FEATURES*WEIGHT_WIDTH  row of B-transpose; same packing.
REQ-016 inputAddr  out  LOG_BATCH_SIZE  read address of A; synchronous memory, 1-cycle latency.
REQ-017 weightAddr  out  LOG_OUTPUT_FEATURES  read address of B-transpose; 1-cycle latency.
REQ-018 outputData  out  OUTPUT_FEATURES*OUTPUT_WIDTH  completed row of C; lane j holds C[row][j].
REQ-019 outputAddr  out  LOG_BATCH_SIZE  row index of outputData.
REQ-020 outputWrEn  out  1  outputData/outputAddr are valid.
REQ-021 outputReady  in  1  sink accepts the row when outputWrEn and outputReady are both high on a clk edge.

Function
REQ-022 FSM states SHALL be IDLE, RUN, DRAIN, WRITE, DONE.
REQ-023 IDLE -> RUN on start; inputAddr is held at the current row index throughout a row.
REQ-024 RUN SHALL issue weightAddr = 0..O-1 on consecutive cycles (one per cycle), then go to DRAIN.
REQ-025 Each dot product SHALL complete 2 cycles after its weightAddr issue (1 memory + 1 registered sum) and be written to lane j of the row buffer.
REQ-026 DRAIN SHALL last exactly 2 cycles, then go to WRITE.
REQ-027 WRITE SHALL hold outputWrEn high with a stable outputData/outputAddr until accepted; back-pressure (outputReady low) SHALL stall with no data change.
REQ-028 On acceptance: if the row is M-1, go to DONE; else increment the row and go to RUN.
REQ-029 DONE SHALL last 1 cycle with done high, then go to IDLE.
REQ-030 start SHALL be ignored while busy; start held high in IDLE after DONE SHALL begin a new run.
REQ-031 Products SHALL be IW+WW bits and accumulated without loss at IW+WW+ceil(log2 N) bits, signed or unsigned per SIGNED.
REQ-032 SATURATE=1: results SHALL clamp to the OUTPUT_WIDTH min/max for the signedness; SATURATE=0: results SHALL take the low OUTPUT_WIDTH bits.
REQ-033 Minimum latency per row SHALL be O+3 cycles; a full run with outputReady tied high SHALL take M*(O+3)+1 cycles from start to done.

Reset
REQ-034 While rst is low: state IDLE; row and column counters 0; inputAddr, weightAddr, outputAddr 0; outputData 0; outputWrEn, busy, done 0.
REQ-035 Reset asserted mid-run SHALL abort immediately, with no partial row written after release.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding and the accumulator-width and saturation-bound constants.
REQ-037 A sub-module dot_product SHALL perform the N-way multiply, adder tree, output register and saturate/truncate, parameterised identically.

Verification
REQ-038 Test 1: A[i][k]=k+1, B = all-ones, outputReady=1 -> every C element = 10, done after 8*11+1 = 89 cycles.
REQ-039 Test 2: SIGNED=1, A all -8 (4-bit), B all 127 -> raw sum -4064, unsaturated; then OUTPUT_WIDTH=8, SATURATE=1 -> -128.
REQ-040 Test 3: outputReady low for 5 cycles in row 3 -> outputWrEn held, data stable, row 3 written once, run extended by 5 cycles.
REQ-041 Test 4: start pulsed during RUN -> ignored; exactly 8 writes and 1 done.
REQ-042 Test 5: rst low during row 2 RUN -> all outputs 0 next cycle; after release, no write until a new start.
REQ-043 Test 6: SATURATE=0, unsigned sum 70000, OUTPUT_WIDTH=16 -> 4464.

Source files
------------

// File: rtl/matrix_mult_pipe_pkg.sv
// rtl/matrix_mult_pipe_pkg.sv - shared FSM encoding, accumulator width and saturation bounds
package matrix_mult_pipe_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } stateType;

    // Cycles between the last weight address issue and the last lane landing in the row buffer
    localparam int DRAIN_CYCLES = 2;

    // Lossless accumulator width: one product plus log2(N) growth bits
    function automatic int accWidth(input int iw, input int ww, input int n);
        return iw + ww + $clog2(n);
    endfunction

    function automatic longint satMax(input int ow, input bit sgn);
        return sgn ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
    endfunction

    function automatic longint satMin(input int ow, input bit sgn);
        return sgn ? -(longint'(1) << (ow - 1)) : longint'(0);
    endfunction

endpackage

// File: rtl/matrix_mult_pipe_if.sv
// rtl/matrix_mult_pipe_if.sv - completed-row write bus with ready back-pressure
interface matrix_mult_pipe_if #(
    parameter int OUTPUT_FEATURES = 8,
    parameter int OUTPUT_WIDTH    = 16,
    parameter int LOG_BATCH_SIZE  = 3
);
    logic [OUTPUT_FEATURES*OUTPUT_WIDTH-1:0] outputData;
    logic [LOG_BATCH_SIZE-1:0]               outputAddr;
    logic                                    outputWrEn;
    logic                                    outputReady;

    modport master (output outputData, output outputAddr, output outputWrEn, input outputReady);
    modport slave  (input outputData, input outputAddr, input outputWrEn, output outputReady);
endinterface

// File: rtl/matrix_mult_pipe_dot_product.sv
// rtl/matrix_mult_pipe_dot_product.sv - N-way multiply, adder tree, saturate/truncate, output register
module dot_product
    import matrix_mult_pipe_pkg::*;
#(
    parameter int INPUT_FEATURES = 4,
    parameter int INPUT_WIDTH    = 4,
    parameter int WEIGHT_WIDTH   = 8,
    parameter int OUTPUT_WIDTH   = 16,
    parameter int SIGNED         = 0,
    parameter int SATURATE       = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [INPUT_FEATURES*INPUT_WIDTH-1:0]  inputData,
    input  logic [INPUT_FEATURES*WEIGHT_WIDTH-1:0] weightData,
    output logic [OUTPUT_WIDTH-1:0]                result
);
    localparam int     ACC_WIDTH = accWidth(INPUT_WIDTH, WEIGHT_WIDTH, INPUT_FEATURES);
    localparam longint SAT_MAX   = satMax(OUTPUT_WIDTH, SIGNED != 0);
    localparam longint SAT_MIN   = satMin(OUTPUT_WIDTH, SIGNED != 0);

    // One extra bit so unsigned operands are carried as non-negative signed values
    logic signed [INPUT_WIDTH:0]  aExt;
    logic signed [WEIGHT_WIDTH:0] wExt;
    logic signed [ACC_WIDTH:0]    sum;
    longint                       sumLong;
    logic [OUTPUT_WIDTH-1:0]      nextResult;

    // Sum of element products, then clamp or wrap into the output width
    always_comb begin
        aExt       = '0;
        wExt       = '0;
        sum        = '0;
        for (int k = 0; k < INPUT_FEATURES; k++) begin
            aExt = {(SIGNED != 0) & inputData[k*INPUT_WIDTH + INPUT_WIDTH - 1],
                    inputData[k*INPUT_WIDTH +: INPUT_WIDTH]};
            wExt = {(SIGNED != 0) & weightData[k*WEIGHT_WIDTH + WEIGHT_WIDTH - 1],
                    weightData[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]};
            sum  = sum + (ACC_WIDTH+1)'(aExt) * (ACC_WIDTH+1)'(wExt);
        end
        sumLong = longint'(sum);
        if (SATURATE != 0 && sumLong > SAT_MAX) begin
            nextResult = OUTPUT_WIDTH'(SAT_MAX);
        end else if (SATURATE != 0 && sumLong < SAT_MIN) begin
            nextResult = OUTPUT_WIDTH'(SAT_MIN);
        end else begin
            nextResult = OUTPUT_WIDTH'(sumLong);
        end
    end

    // Registered sum stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
        end else begin
            result <= nextResult;
        end
    end
endmodule

// File: rtl/matrix_mult_pipe.sv
// rtl/matrix_mult_pipe.sv - row-at-a-time C = A x B-transpose with a buffered row write-out
module matrix_mult_pipe
    import matrix_mult_pipe_pkg::*;
#(
    parameter int BATCH_SIZE          = 8,
    parameter int LOG_BATCH_SIZE      = 3,
    parameter int INPUT_FEATURES      = 4,
    parameter int OUTPUT_FEATURES     = 8,
    parameter int LOG_OUTPUT_FEATURES = 3,
    parameter int INPUT_WIDTH         = 4,
    parameter int WEIGHT_WIDTH        = 8,
    parameter int OUTPUT_WIDTH        = 16,
    parameter int SIGNED              = 0,
    parameter int SATURATE            = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    input  logic [INPUT_FEATURES*INPUT_WIDTH-1:0]  inputData,
    input  logic [INPUT_FEATURES*WEIGHT_WIDTH-1:0] weightData,
    output logic [LOG_BATCH_SIZE-1:0]              inputAddr,
    output logic [LOG_OUTPUT_FEATURES-1:0]         weightAddr,
    matrix_mult_pipe_if.master                     outBus
);
    localparam logic [LOG_BATCH_SIZE-1:0]      LAST_ROW   = LOG_BATCH_SIZE'(BATCH_SIZE - 1);
    localparam logic [LOG_OUTPUT_FEATURES-1:0] LAST_COL   = LOG_OUTPUT_FEATURES'(OUTPUT_FEATURES - 1);
    localparam logic [1:0]                     LAST_DRAIN = 2'(DRAIN_CYCLES - 1);

    stateType                       state, nextState;
    logic [LOG_BATCH_SIZE-1:0]      row, nextRow;
    logic [LOG_OUTPUT_FEATURES-1:0] col, nextCol;
    logic [1:0]                     drainCnt, nextDrainCnt;

    logic                           memValid, sumValid;
    logic [LOG_OUTPUT_FEATURES-1:0] memCol, sumCol;
    logic [OUTPUT_WIDTH-1:0]        laneResult;
    logic [OUTPUT_WIDTH-1:0]        rowBuf [OUTPUT_FEATURES];

    assign inputAddr         = row;
    assign weightAddr        = col;
    assign outBus.outputAddr = row;

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            row      <= '0;
            col      <= '0;
            drainCnt <= '0;
        end else begin
            state    <= nextState;
            row      <= nextRow;
            col      <= nextCol;
            drainCnt <= nextDrainCnt;
        end
    end

    // Next-state and control outputs
    always_comb begin
        nextState         = state;
        nextRow           = row;
        nextCol           = col;
        nextDrainCnt      = drainCnt;
        busy              = (state != IDLE);
        done              = (state == DONE);
        outBus.outputWrEn = (state == WRITE);
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = RUN;
                    nextRow   = '0;
                    nextCol   = '0;
                end
            end
            RUN: begin
                if (col == LAST_COL) begin
                    nextState    = DRAIN;
                    nextCol      = '0;
                    nextDrainCnt = '0;
                end else begin
                    nextCol = col + LOG_OUTPUT_FEATURES'(1);
                end
            end
            DRAIN: begin
                if (drainCnt == LAST_DRAIN) begin
                    nextState = WRITE;
                end else begin
                    nextDrainCnt = drainCnt + 2'd1;
                end
            end
            WRITE: begin
                if (outBus.outputReady) begin
                    if (row == LAST_ROW) begin
                        nextState = DONE;
                    end else begin
                        nextRow   = row + LOG_BATCH_SIZE'(1);
                        nextState = RUN;
                    end
                end
            end
            DONE: begin
                nextState = IDLE;
                nextRow   = '0;
            end
            default: nextState = IDLE;
        endcase
    end

    // Column tag follows each issue through the memory and sum stages
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memValid <= 1'b0;
            memCol   <= '0;
            sumValid <= 1'b0;
            sumCol   <= '0;
        end else begin
            memValid <= (state == RUN);
            memCol   <= col;
            sumValid <= memValid;
            sumCol   <= memCol;
        end
    end

    dot_product #(
        .INPUT_FEATURES (INPUT_FEATURES),
        .INPUT_WIDTH    (INPUT_WIDTH),
        .WEIGHT_WIDTH   (WEIGHT_WIDTH),
        .OUTPUT_WIDTH   (OUTPUT_WIDTH),
        .SIGNED         (SIGNED),
        .SATURATE       (SATURATE)
    ) dotProduct (
        .clk        (clk),
        .rst        (rst),
        .inputData  (inputData),
        .weightData (weightData),
        .result     (laneResult)
    );

    // Row buffer: each finished dot product lands in its lane; untouched while WRITE waits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < OUTPUT_FEATURES; j++) begin
                rowBuf[j] <= '0;
            end
        end else if (sumValid) begin
            rowBuf[sumCol] <= laneResult;
        end
    end

    // Flatten the row buffer onto the output bus
    always_comb begin
        outBus.outputData = '0;
        for (int j = 0; j < OUTPUT_FEATURES; j++) begin
            outBus.outputData[j*OUTPUT_WIDTH +: OUTPUT_WIDTH] = rowBuf[j];
        end
    end
endmodule

// File: tb/tb_matrix_mult_pipe.sv
// tb/tb_matrix_mult_pipe.sv - four configurations run in lockstep against an arithmetic model
module tb_matrix_mult_pipe;
    localparam int M = 8;
    localparam int N = 4;
    localparam int O = 8;
    localparam int CFG_IW  [4] = '{4, 4, 4, 8};
    localparam int CFG_OW  [4] = '{16, 16, 8, 16};
    localparam int CFG_SG  [4] = '{0, 1, 1, 0};
    localparam int CFG_SAT [4] = '{1, 1, 1, 0};

    typedef struct {
        int     a;
        int     b;
        longint e0;
        longint e1;
        longint e2;
        longint e3;
    } vecT;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b1;

    logic [31:0]  inData [4];
    logic [31:0]  wData  [4];
    logic [2:0]   inAddr [4];
    logic [2:0]   wAddr  [4];
    logic         busyV  [4];
    logic         doneV  [4];
    logic         wrEn   [4];
    logic [2:0]   oAddr  [4];
    logic [127:0] oData  [4];

    int     memA [M][N];
    int     memB [O][N];
    int     checks = 0;
    int     errors = 0;
    int     wrTotal [4];
    int     doneCnt [4];
    int     rowWrites [4][M];
    logic [127:0] rowData [4][M];
    longint expConst [4];
    int     cyc;
    vecT    vecs [4];

    always #5 clk = ~clk;

    matrix_mult_pipe_if #(.OUTPUT_FEATURES(O), .OUTPUT_WIDTH(16), .LOG_BATCH_SIZE(3)) bus0 ();
    matrix_mult_pipe_if #(.OUTPUT_FEATURES(O), .OUTPUT_WIDTH(16), .LOG_BATCH_SIZE(3)) bus1 ();
    matrix_mult_pipe_if #(.OUTPUT_FEATURES(O), .OUTPUT_WIDTH(8),  .LOG_BATCH_SIZE(3)) bus2 ();
    matrix_mult_pipe_if #(.OUTPUT_FEATURES(O), .OUTPUT_WIDTH(16), .LOG_BATCH_SIZE(3)) bus3 ();

    matrix_mult_pipe #(.SIGNED(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .busy(busyV[0]), .done(doneV[0]),
        .inputData(inData[0][15:0]), .weightData(wData[0]), .inputAddr(inAddr[0]),
        .weightAddr(wAddr[0]), .outBus(bus0.master));
    matrix_mult_pipe #(.SIGNED(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .busy(busyV[1]), .done(doneV[1]),
        .inputData(inData[1][15:0]), .weightData(wData[1]), .inputAddr(inAddr[1]),
        .weightAddr(wAddr[1]), .outBus(bus1.master));
    matrix_mult_pipe #(.SIGNED(1), .OUTPUT_WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .start(start), .busy(busyV[2]), .done(doneV[2]),
        .inputData(inData[2][15:0]), .weightData(wData[2]), .inputAddr(inAddr[2]),
        .weightAddr(wAddr[2]), .outBus(bus2.master));
    matrix_mult_pipe #(.INPUT_WIDTH(8), .SATURATE(0)) dut3 (
        .clk(clk), .rst(rst), .start(start), .busy(busyV[3]), .done(doneV[3]),
        .inputData(inData[3]), .weightData(wData[3]), .inputAddr(inAddr[3]),
        .weightAddr(wAddr[3]), .outBus(bus3.master));

    assign bus0.outputReady = ready;
    assign bus1.outputReady = ready;
    assign bus2.outputReady = ready;
    assign bus3.outputReady = ready;
    assign wrEn[0] = bus0.outputWrEn;
    assign wrEn[1] = bus1.outputWrEn;
    assign wrEn[2] = bus2.outputWrEn;
    assign wrEn[3] = bus3.outputWrEn;
    assign oAddr[0] = bus0.outputAddr;
    assign oAddr[1] = bus1.outputAddr;
    assign oAddr[2] = bus2.outputAddr;
    assign oAddr[3] = bus3.outputAddr;
    assign oData[0] = bus0.outputData;
    assign oData[1] = bus1.outputData;
    assign oData[2] = {64'd0, bus2.outputData};
    assign oData[3] = bus3.outputData;

    function automatic logic [31:0] packRow(input bit isA, input int r, input int w);
        logic [31:0] v;
        int raw;
        v = '0;
        for (int k = 0; k < N; k++) begin
            raw = isA ? memA[r][k] : memB[r][k];
            for (int b = 0; b < w; b++) v[k*w + b] = raw[b];
        end
        return v;
    endfunction

    // Synchronous read memories, one-cycle latency
    always @(posedge clk) begin
        for (int d = 0; d < 4; d++) begin
            inData[d] <= packRow(1'b1, int'(inAddr[d]), CFG_IW[d]);
            wData[d]  <= packRow(1'b0, int'(wAddr[d]), 8);
        end
    end

    function automatic longint interp(input int raw, input int w, input int sgn);
        longint v;
        v = longint'(raw) & ((longint'(1) << w) - 1);
        if (sgn != 0 && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
        return v;
    endfunction

    function automatic longint expLane(input int d, input int r, input int j);
        longint s, hi, lo;
        int ow;
        ow = CFG_OW[d];
        s = 0;
        for (int k = 0; k < N; k++)
            s = s + interp(memA[r][k], CFG_IW[d], CFG_SG[d]) * interp(memB[j][k], 8, CFG_SG[d]);
        if (CFG_SAT[d] != 0) begin
            hi = (CFG_SG[d] != 0) ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
            lo = (CFG_SG[d] != 0) ? -(longint'(1) << (ow - 1)) : 0;
            if (s > hi) s = hi;
            if (s < lo) s = lo;
        end
        return s & ((longint'(1) << ow) - 1);
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clearLog();
        for (int d = 0; d < 4; d++) begin
            wrTotal[d] = 0;
            doneCnt[d] = 0;
            for (int r = 0; r < M; r++) begin
                rowWrites[d][r] = 0;
                rowData[d][r] = '0;
            end
        end
    endtask

    task automatic logCycle();
        for (int d = 0; d < 4; d++) begin
            if (wrEn[d] && ready) begin
                wrTotal[d]++;
                rowWrites[d][oAddr[d]]++;
                rowData[d][oAddr[d]] = oData[d];
            end
            if (doneV[d]) doneCnt[d]++;
        end
    endtask

    task automatic checkZero(input string tag);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s d%0d busy", tag, d), longint'(busyV[d]), 0);
            check($sformatf("%s d%0d done", tag, d), longint'(doneV[d]), 0);
            check($sformatf("%s d%0d wren", tag, d), longint'(wrEn[d]), 0);
            check($sformatf("%s d%0d inaddr", tag, d), longint'(inAddr[d]), 0);
            check($sformatf("%s d%0d waddr", tag, d), longint'(wAddr[d]), 0);
            check($sformatf("%s d%0d oaddr", tag, d), longint'(oAddr[d]), 0);
            check($sformatf("%s d%0d odata_zero", tag, d), longint'(oData[d] == '0), 1);
        end
    endtask

    // Starts a run from a negedge; returns the cycle (1 = first RUN cycle) in which done is seen
    task automatic runMatrix(input int stallRow, input int stallLen, input int startAt, output int cycles);
        int stalled;
        bit seenDone, haveHeld;
        logic [127:0] held;
        stalled = 0; seenDone = 0; haveHeld = 0; cycles = 0; held = '0;
        clearLog();
        ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int t = 1; t <= 2000 && !seenDone; t++) begin
            start = (t == startAt);
            ready = 1'b1;
            if (stallLen > 0 && wrEn[0] && oAddr[0] == 3'(stallRow)) begin
                if (stalled < stallLen) begin
                    ready = 1'b0;
                    stalled++;
                end
                if (haveHeld) check("stall_hold_data", longint'(oData[0] == held), 1);
                else begin
                    held = oData[0];
                    haveHeld = 1'b1;
                end
            end
            logCycle();
            if (doneV[0]) begin
                seenDone = 1'b1;
                cycles = t;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", longint'(seenDone), 1);
        repeat (3) begin
            logCycle();
            @(negedge clk);
        end
        check("idle_after_run", longint'(busyV[0]), 0);
    endtask

    task automatic checkResults(input string tag, input bit useConst);
        longint lane, mask;
        for (int d = 0; d < 4; d++) begin
            mask = (longint'(1) << CFG_OW[d]) - 1;
            check($sformatf("%s d%0d writes", tag, d), wrTotal[d], M);
            check($sformatf("%s d%0d dones", tag, d), doneCnt[d], 1);
            for (int r = 0; r < M; r++) begin
                check($sformatf("%s d%0d row%0d once", tag, d, r), rowWrites[d][r], 1);
                for (int j = 0; j < O; j++) begin
                    lane = longint'(rowData[d][r] >> (j * CFG_OW[d])) & mask;
                    check($sformatf("%s d%0d C[%0d][%0d]", tag, d, r, j), lane, expLane(d, r, j));
                    if (useConst)
                        check($sformatf("%s d%0d const C[%0d][%0d]", tag, d, r, j), lane, expConst[d]);
                end
            end
        end
    endtask

    task automatic loadUniform(input int a, input int b);
        for (int r = 0; r < M; r++)
            for (int k = 0; k < N; k++) begin
                memA[r][k] = a;
                memB[r][k] = b;
            end
    endtask

    task automatic loadRandom();
        for (int r = 0; r < M; r++)
            for (int k = 0; k < N; k++) begin
                memA[r][k] = int'($urandom_range(0, 255));
                memB[r][k] = int'($urandom_range(0, 255));
            end
    endtask

    initial begin
        vecs[0] = '{a: 'hF8, b: 127, e0: 4064,  e1: 61472, e2: 128, e3: 60448};
        vecs[1] = '{a: 70,   b: 250, e0: 6000,  e1: 65392, e2: 128, e3: 4464};
        vecs[2] = '{a: 7,    b: 127, e0: 3556,  e1: 3556,  e2: 127, e3: 3556};
        vecs[3] = '{a: 'hFF, b: 255, e0: 15300, e1: 4,     e2: 4,   e3: 63492};
        loadUniform(0, 0);

        repeat (3) @(negedge clk);
        checkZero("reset");
        rst = 1'b1;
        @(negedge clk);

        // A[i][k] = k+1, B all ones: every element 10, done in cycle M*(O+3)+1
        for (int r = 0; r < M; r++)
            for (int k = 0; k < N; k++) begin
                memA[r][k] = k + 1;
                memB[r][k] = 1;
            end
        runMatrix(-1, 0, 0, cyc);
        check("t1 cycles", cyc, M * (O + 3) + 1);
        expConst = '{10, 10, 10, 10};
        checkResults("t1", 1'b1);

        // Uniform-matrix vectors across signedness, saturation and truncation
        for (int v = 0; v < 4; v++) begin
            loadUniform(vecs[v].a, vecs[v].b);
            expConst = '{vecs[v].e0, vecs[v].e1, vecs[v].e2, vecs[v].e3};
            runMatrix(-1, 0, 0, cyc);
            check($sformatf("vec%0d cycles", v), cyc, 89);
            checkResults($sformatf("vec%0d", v), 1'b1);
        end

        // Back-pressure in row 3 for 5 cycles
        loadRandom();
        runMatrix(3, 5, 0, cyc);
        check("t3 cycles", cyc, 89 + 5);
        checkResults("t3", 1'b0);

        // Start pulse during RUN is ignored
        loadRandom();
        runMatrix(-1, 0, 5, cyc);
        check("t4 cycles", cyc, 89);
        checkResults("t4", 1'b0);

        // Reset during row 2 RUN aborts; nothing written after release
        loadRandom();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        check("t5 row2", longint'(inAddr[0]), 2);
        check("t5 busy", longint'(busyV[0]), 1);
        rst = 1'b0;
        @(negedge clk);
        checkZero("t5 abort");
        rst = 1'b1;
        clearLog();
        repeat (30) begin
            logCycle();
            @(negedge clk);
        end
        for (int d = 0; d < 4; d++) begin
            check($sformatf("t5 d%0d no writes", d), wrTotal[d], 0);
            check($sformatf("t5 d%0d no done", d), doneCnt[d], 0);
            check($sformatf("t5 d%0d idle", d), longint'(busyV[d]), 0);
        end

        // Random matrices after recovery
        for (int n = 0; n < 3; n++) begin
            loadRandom();
            runMatrix(-1, 0, 0, cyc);
            check($sformatf("rand%0d cycles", n), cyc, 89);
            checkResults($sformatf("rand%0d", n), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
